// File: rtl/tape_lcd_printer_pkg.sv
// tm_defs_pkg: tape symbol encodings, LCD command bytes and FSM state types shared by the tape printer.
package tm_defs_pkg;
   localparam logic [1:0] SYM_BLANK = 2'b00;
   localparam logic [1:0] SYM_ZERO  = 2'b01;
   localparam logic [1:0] SYM_ONE   = 2'b10;
   localparam logic [1:0] SYM_HASH  = 2'b11;
   localparam logic [7:0] FUNC_SET  = 8'h38;
   localparam logic [7:0] DISP_ON   = 8'h0C;
   localparam logic [7:0] CLEAR     = 8'h01;
   localparam logic [7:0] ENTRY     = 8'h06;
   localparam logic [7:0] LINE1     = 8'h80;
   localparam logic [7:0] LINE2     = 8'hC0;
   localparam logic [7:0] HEAD_MARK = 8'h5E;
   localparam int INIT_LAST = 5;
   typedef enum logic [3:0] {
      PWR_WAIT, INIT, IDLE, HOME, FETCH, FETCH_WAIT, CAPTURE, CHAR, DONE
   } prn_state_e;
   typedef enum logic [1:0] {W_IDLE, W_SETUP, W_EN, W_WAIT} wr_state_e;
   function automatic logic [7:0] sym2ascii(input logic [1:0] s);
      return s == SYM_BLANK ? 8'h20 : s == SYM_ZERO ? 8'h30 : s == SYM_ONE ? 8'h31 : 8'h23;
   endfunction
endpackage

// File: rtl/tape_lcd_printer_if.sv
// tape_lcd_printer_if: core request, tape read port and LCD pins of the tape printer.
interface tape_lcd_printer_if #(parameter int AW = 10);
   logic          print_start;
   logic [AW-1:0] head_pos;
   logic          print_done;
   logic          mem_access;
   logic          mem_rw;
   logic [AW:0]   mem_addr;
   logic [1:0]    mem_io_pin;
   logic [7:0]    lcd_data;
   logic          lcd_rs;
   logic          lcd_rw;
   logic          lcd_en;
   logic          lcd_on;
   modport master (
      output print_start, head_pos, mem_io_pin,
      input  print_done, mem_access, mem_rw, mem_addr, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on
   );
   modport slave (
      input  print_start, head_pos, mem_io_pin,
      output print_done, mem_access, mem_rw, mem_addr, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on
   );
endinterface

// File: rtl/tape_lcd_printer_lcd_byte_writer.sv
// lcd_byte_writer: one HD44780 byte write: setup cycle, enable pulse, then settle wait.
module lcd_byte_writer
   import tm_defs_pkg::*;
#(
   parameter int EN_CYCLES   = 12,
   parameter int WAIT_CYCLES = 2500,
   parameter int CLEAR_WAIT  = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic       rs,
   input  logic [7:0] data,
   input  logic       long_wait,
   output logic       lcd_en,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       busy,
   output logic       done
);
   localparam int MAXW = CLEAR_WAIT > WAIT_CYCLES ? CLEAR_WAIT : WAIT_CYCLES;
   localparam int MAXC = MAXW > EN_CYCLES ? MAXW : EN_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   wr_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, wait_last;
   logic [7:0] data_q, data_d;
   logic rs_q, rs_d, long_q, long_d;
   assign wait_last = long_q ? CW'(CLEAR_WAIT - 1) : CW'(WAIT_CYCLES - 1);
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      data_d = data_q;
      rs_d = rs_q;
      long_d = long_q;
      done = 1'b0;
      case (state_q)
         W_IDLE: if (go) begin
            data_d = data;
            rs_d = rs;
            long_d = long_wait;
            state_d = W_SETUP;
         end
         W_SETUP: begin
            cnt_d = '0;
            state_d = W_EN;
         end
         W_EN: begin
            cnt_d = cnt_q == CW'(EN_CYCLES - 1) ? '0 : cnt_q + 1'b1;
            state_d = cnt_q == CW'(EN_CYCLES - 1) ? W_WAIT : W_EN;
         end
         W_WAIT: begin
            done = cnt_q == wait_last;
            cnt_d = cnt_q + 1'b1;
            state_d = done ? W_IDLE : W_WAIT;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= W_IDLE;
         cnt_q <= '0;
         data_q <= '0;
         rs_q <= 1'b0;
         long_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         data_q <= data_d;
         rs_q <= rs_d;
         long_q <= long_d;
      end
   end
   assign lcd_en = state_q == W_EN;
   assign lcd_data = data_q;
   assign lcd_rs = rs_q;
   assign busy = state_q != W_IDLE;
endmodule

// File: rtl/tape_lcd_printer.sv
// tape_lcd_printer: initialises an HD44780 and prints a tape window centred on the head to line 1.
module tape_lcd_printer
   import tm_defs_pkg::*;
#(
   parameter int TAPE_SIZE    = 1024,
   parameter int WINDOW       = 16,
   parameter int POWERUP_WAIT = 750000,
   parameter int EN_CYCLES    = 12,
   parameter int WAIT_CYCLES  = 2500,
   parameter int CLEAR_WAIT   = 100000
) (
   input logic clk,
   input logic rst,
   tape_lcd_printer_if.slave bus
);
   localparam int AW = $clog2(TAPE_SIZE);
   localparam int IW = $clog2(WINDOW);
   localparam int PW = $clog2(POWERUP_WAIT + 1);
   localparam logic [AW-1:0] HALF = AW'(WINDOW / 2);
   prn_state_e state_q, state_d;
   logic [PW-1:0] cnt_q, cnt_d;
   logic [2:0] step_q, step_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [AW-1:0] base_q, base_d, addr_q, addr_d, fetch_addr;
   logic [1:0] sym_q, sym_d;
   logic armed_q, armed_d, rw_q, rw_d, sent_q, sent_d, on_q;
   logic w_go, w_rs, w_long, w_busy, w_done, lcd_en, lcd_rs;
   logic [7:0] w_data, init_byte, lcd_data;
   assign fetch_addr = base_q + AW'(idx_q);
   // each byte state issues exactly one write; sent_q blocks a re-issue until the writer reports done
   always_comb begin
      init_byte = step_q == 3'd0 ? FUNC_SET : step_q == 3'd1 ? DISP_ON : step_q == 3'd2 ? CLEAR :
                  step_q == 3'd3 ? ENTRY : step_q == 3'd4 ? LINE2 + 8'(WINDOW / 2) : HEAD_MARK;
      w_rs = (state_q == INIT && step_q == 3'(INIT_LAST)) || state_q == CHAR;
      w_data = state_q == INIT ? init_byte : state_q == HOME ? LINE1 : sym2ascii(sym_q);
      w_long = !w_rs && w_data == CLEAR;
      w_go = (state_q == INIT || state_q == HOME || state_q == CHAR) && !sent_q && !w_busy;
      sent_d = w_go | (sent_q & ~w_done);
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      step_d = step_q;
      idx_d = idx_q;
      base_d = base_q;
      addr_d = addr_q;
      sym_d = sym_q;
      rw_d = rw_q;
      armed_d = armed_q | ~bus.print_start;
      case (state_q)
         PWR_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == PW'(POWERUP_WAIT - 1)) begin
               step_d = '0;
               state_d = INIT;
            end
         end
         INIT: if (w_done) begin
            step_d = step_q + 3'd1;
            state_d = step_q == 3'(INIT_LAST) ? IDLE : INIT;
         end
         IDLE: if (bus.print_start && armed_q) begin
            base_d = bus.head_pos - HALF;
            rw_d = 1'b1;
            state_d = HOME;
         end
         HOME: if (w_done) begin
            idx_d = '0;
            state_d = FETCH;
         end
         FETCH: begin
            addr_d = fetch_addr;
            state_d = FETCH_WAIT;
         end
         FETCH_WAIT: state_d = CAPTURE;
         CAPTURE: begin
            sym_d = bus.mem_io_pin;
            state_d = CHAR;
         end
         CHAR: if (w_done) begin
            idx_d = idx_q + 1'b1;
            state_d = idx_q == IW'(WINDOW - 1) ? DONE : FETCH;
         end
         DONE: begin
            rw_d = 1'b0;
            armed_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = PWR_WAIT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PWR_WAIT;
         cnt_q <= '0;
         step_q <= '0;
         idx_q <= '0;
         base_q <= '0;
         addr_q <= '0;
         sym_q <= '0;
         rw_q <= 1'b0;
         armed_q <= 1'b1;
         sent_q <= 1'b0;
         on_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         step_q <= step_d;
         idx_q <= idx_d;
         base_q <= base_d;
         addr_q <= addr_d;
         sym_q <= sym_d;
         rw_q <= rw_d;
         armed_q <= armed_d;
         sent_q <= sent_d;
         on_q <= 1'b1;
      end
   end
   lcd_byte_writer #(
      .EN_CYCLES(EN_CYCLES),
      .WAIT_CYCLES(WAIT_CYCLES),
      .CLEAR_WAIT(CLEAR_WAIT)
   ) u_writer (
      .clk(clk),
      .rst(rst),
      .go(w_go),
      .rs(w_rs),
      .data(w_data),
      .long_wait(w_long),
      .lcd_en(lcd_en),
      .lcd_data(lcd_data),
      .lcd_rs(lcd_rs),
      .busy(w_busy),
      .done(w_done)
   );
   assign bus.print_done = state_q == DONE;
   assign bus.mem_access = state_q == FETCH;
   assign bus.mem_rw = rw_q;
   assign bus.mem_addr = {1'b0, state_q == FETCH ? fetch_addr : addr_q};
   assign bus.lcd_data = lcd_data;
   assign bus.lcd_rs = lcd_rs;
   assign bus.lcd_rw = 1'b0;
   assign bus.lcd_en = lcd_en;
   assign bus.lcd_on = on_q;
endmodule
